src_ctrl_seq: RTL and testbench
===============================

Name: src_ctrl_seq

Overview:
- Parametrised multi-cycle control sequencer for the Mini SRC datapath; successor to the fixed 5-bit, zero-wait control unit.
- Moore FSM: decodes the IR opcode and drives a packed control word into the bus/register/ALU/memory datapath.
- Adds memory wait-states with timeout, illegal-opcode fault, stop/go at instruction boundaries, and a retired-instruction counter.

Parameters:
- IR_W, 32, instruction register width; opcode field is ir[IR_W-1 -: OPC_W].
- OPC_W, 5, opcode width (>=5); package opcode values are zero-extended to OPC_W.
- CNT_W, 16, instr_count width.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clock in 1: system clock, rising edge.
- reset in 1: asynchronous, active-high.
- ir in IR_W: current instruction register contents.
- con_ff in 1: branch condition flip-flop.
- mem_ready in 1: memory completion handshake.
- stop in 1: halt request.
- go in 1: resume from HALT.
- ctrl out 32: packed control word; bit map in package.
- alu_op out OPC_W: opcode latched in DEC.
- run out 1: processor running.
- illegal out 1: sticky illegal-opcode flag.
- mem_fault out 1: sticky memory-timeout flag.
- instr_count out CNT_W: instructions decoded.
- state_dbg out 8: current state encoding.

Behaviour:
- Reset (asynchronous): state=RST; ctrl=0, alu_op=0, run=0, illegal=0, mem_fault=0, instr_count=0, wait counter=0.
- RST -> F0 unconditionally. run=1 in every state except RST, HALT and FAULT.
- ctrl is a pure decode of registered state (Moore). Bits not listed for a state are 0.
- Fetch sequence:
  - F0: PCout MARen IncPC Zen.
  - F1: ZLOout Pen Read MDRen. Holds in F1 until mem_ready=1.
  - F2: MDRout IRen.
  - DEC: ctrl=0. Latches alu_op=opcode, increments instr_count (wraps modulo 2^CNT_W), then branches on opcode.
- ALU reg ops (add sub and or shr shra shl ror rol):
  - T3: Grb Rout Yen.
  - T4: Grc Rout Zen.
  - T5: ZLOout Gra Rin.
- Immediate ops (addi andi ori): same as ALU reg ops, except T4 = Cout Zen.
- mul/div: T3, T4 as ALU reg ops; T5: ZLOout LOen; T6: ZHIout HIen.
- neg/not: T3: Grb Rout Zen; T4: ZLOout Gra Rin.
- ld:
  - T3: Grb BAout Yen.
  - T4: Cout Zen.
  - T5: ZLOout MARen.
  - T6: Read MDRen, waits for mem_ready.
  - T7: MDRout Gra Rin.
- ldi: T3, T4 as ld; T5: ZLOout Gra Rin.
- st: T3–T5 as ld; T6: Gra Rout MDRen; T7: Write, waits for mem_ready.
- br:
  - T3: Gra Rout ConIn.
  - T4: PCout Yen.
  - T5: Cout Zen.
  - T6: ZLOout, plus Pen only if con_ff=1.
- jr: T3: Gra Rout Pen.
- jal: T3: PCout Gra Rin; T4: Grb Rout Pen.
- mfhi / mflo / in: single state T3 with HIout / LOout / InPortout respectively, plus Gra Rin.
- out: T3: Gra Rout OutPorten.
- nop: no execute state; DEC goes straight to the boundary.
- halt: DEC -> HALT.
- Any other opcode: DEC -> FAULT and set illegal.
- Instruction boundary (last state of every instruction, and DEC for nop): next state is HALT if stop=1, else F0.
  - stop asserted mid-instruction lets the instruction complete.
- HALT: ctrl=0. Goes to F0 when go=1 and stop=0; otherwise holds.
- FAULT: ctrl=0, run=0. Held until reset; go is ignored.
- Wait states (F1, ld T6, st T7):
  - Wait counter clears on entry and increments each cycle with mem_ready=0.
  - mem_ready=1 advances on that edge and clears the counter.
  - If the counter equals MEM_TIMEOUT (nonzero) with mem_ready=0: go to FAULT and set mem_fault.
  - ctrl is held constant throughout the wait.
- Simultaneous events:
  - reset dominates everything.
  - stop and go both high in HALT: remain in HALT.
  - mem_ready arriving on the timeout cycle: completion wins.

Decomposition:
- Package src_ctrl_pkg holds:
  - state encodings (localparam 8-bit);
  - opcode constants (ADD=5'b00011, SUB=00100, SHR=00101, SHRA=00110, SHL=00111, ROR=01000, ROL=01001, AND=01010, OR=01011, ADDI=01100, ANDI=01101, ORI=01110, MUL=01111, DIV=10000, NEG=10001, NOT=10010, BR=10011, JR=10100, JAL=10101, IN=10110, OUT=10111, MFHI=11000, MFLO=11001, NOP=11010, HALT=11011, LD=00000, LDI=00001, ST=00010);
  - ctrl bit indices, 0–26: PCout Pen IncPC MARen MDRen MDRout Read Write IRen Yen Zen ZHIout ZLOout HIen LOen HIout LOout Gra Grb Grc Rin Rout BAout Cout ConIn InPortout OutPorten. Bits 27–31 are reserved, 0.
- One sub-module: src_mem_wait, the wait counter/timeout. Inputs: active, mem_ready. Outputs: done, timeout.

Test Plan:
- reset mid-F1 with mem_ready=0: next cycle state=RST, ctrl=0, instr_count=0; one cycle later state=F0, ctrl has PCout|MARen|IncPC|Zen.
- ir opcode ADD, mem_ready=1: F0 F1 F2 DEC T3 T4 T5 F0 in 8 cycles; alu_op=3; T5 ctrl = ZLOout|Gra|Rin; instr_count=1.
- ld with mem_ready low 3 cycles in T6: T6 lasts 4 cycles with Read|MDRen constant; then T7 MDRout|Gra|Rin.
- MEM_TIMEOUT=4, mem_ready held 0 in F1: FAULT after 4 waiting cycles; mem_fault=1, run=0; go=1 has no effect.
- br with con_ff=0 and con_ff=1: T6 Pen bit is 0 and 1 respectively; all other T6 bits identical.
- opcode 5'b11111: DEC -> FAULT, illegal=1. Separately, stop=1 during mul T4: completes T6, enters HALT; go=1 -> F0 next cycle.

Source files
------------

// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer: state encodings,
// opcodes, control-word bit map and the per-state control decode.
package src_ctrl_pkg;

  localparam int unsigned CTRL_W = 32;

  typedef enum logic [7:0] {
    S_RST   = 8'h00,
    S_F0    = 8'h01,
    S_F1    = 8'h02,
    S_F2    = 8'h03,
    S_DEC   = 8'h04,
    S_T3    = 8'h05,
    S_T4    = 8'h06,
    S_T5    = 8'h07,
    S_T6    = 8'h08,
    S_T7    = 8'h09,
    S_HALT  = 8'h0A,
    S_FAULT = 8'h0B
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Instruction classes that share an execute sequence
  typedef enum logic [4:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR, C_JR,
    C_JAL, C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
  } op_class_t;

  localparam int unsigned CB_PCOUT     = 0;
  localparam int unsigned CB_PEN       = 1;
  localparam int unsigned CB_INCPC     = 2;
  localparam int unsigned CB_MAREN     = 3;
  localparam int unsigned CB_MDREN     = 4;
  localparam int unsigned CB_MDROUT    = 5;
  localparam int unsigned CB_READ      = 6;
  localparam int unsigned CB_WRITE     = 7;
  localparam int unsigned CB_IREN      = 8;
  localparam int unsigned CB_YEN       = 9;
  localparam int unsigned CB_ZEN       = 10;
  localparam int unsigned CB_ZHIOUT    = 11;
  localparam int unsigned CB_ZLOOUT    = 12;
  localparam int unsigned CB_HIEN      = 13;
  localparam int unsigned CB_LOEN      = 14;
  localparam int unsigned CB_HIOUT     = 15;
  localparam int unsigned CB_LOOUT     = 16;
  localparam int unsigned CB_GRA       = 17;
  localparam int unsigned CB_GRB       = 18;
  localparam int unsigned CB_GRC       = 19;
  localparam int unsigned CB_RIN       = 20;
  localparam int unsigned CB_ROUT      = 21;
  localparam int unsigned CB_BAOUT     = 22;
  localparam int unsigned CB_COUT      = 23;
  localparam int unsigned CB_CONIN     = 24;
  localparam int unsigned CB_INPORTOUT = 25;
  localparam int unsigned CB_OUTPORTEN = 26;

  function automatic logic [CTRL_W-1:0] cb(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:      return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:             return C_IMM;
      OP_MUL, OP_DIV:                       return C_MULDIV;
      OP_NEG, OP_NOT:                       return C_UNARY;
      OP_LD:                                return C_LD;
      OP_LDI:                               return C_LDI;
      OP_ST:                                return C_ST;
      OP_BR:                                return C_BR;
      OP_JR:                                return C_JR;
      OP_JAL:                               return C_JAL;
      OP_MFHI:                              return C_MFHI;
      OP_MFLO:                              return C_MFLO;
      OP_IN:                                return C_IN;
      OP_OUT:                               return C_OUT;
      OP_NOP:                               return C_NOP;
      OP_HALT:                              return C_HALT;
      default:                              return C_ILL;
    endcase
  endfunction

  // Final execute state of each class; leaving it is an instruction boundary
  function automatic state_t last_state(input op_class_t c);
    case (c)
      C_ALU, C_IMM, C_LDI:  return S_T5;
      C_MULDIV, C_BR:       return S_T6;
      C_UNARY, C_JAL:       return S_T4;
      C_LD, C_ST:           return S_T7;
      default:              return S_T3;
    endcase
  endfunction

  function automatic state_t next_t(input state_t s);
    case (s)
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_FAULT;
    endcase
  endfunction

  function automatic logic [CTRL_W-1:0] ctrl_word(input state_t s, input op_class_t c,
                                                  input logic con);
    logic [CTRL_W-1:0] w;
    w = '0;
    case (s)
      S_F0: w = cb(CB_PCOUT) | cb(CB_MAREN) | cb(CB_INCPC) | cb(CB_ZEN);
      S_F1: w = cb(CB_ZLOOUT) | cb(CB_PEN) | cb(CB_READ) | cb(CB_MDREN);
      S_F2: w = cb(CB_MDROUT) | cb(CB_IREN);
      S_T3: case (c)
        C_ALU, C_IMM, C_MULDIV: w = cb(CB_GRB) | cb(CB_ROUT) | cb(CB_YEN);
        C_UNARY:                w = cb(CB_GRB) | cb(CB_ROUT) | cb(CB_ZEN);
        C_LD, C_LDI, C_ST:      w = cb(CB_GRB) | cb(CB_BAOUT) | cb(CB_YEN);
        C_BR:                   w = cb(CB_GRA) | cb(CB_ROUT) | cb(CB_CONIN);
        C_JR:                   w = cb(CB_GRA) | cb(CB_ROUT) | cb(CB_PEN);
        C_JAL:                  w = cb(CB_PCOUT) | cb(CB_GRA) | cb(CB_RIN);
        C_MFHI:                 w = cb(CB_HIOUT) | cb(CB_GRA) | cb(CB_RIN);
        C_MFLO:                 w = cb(CB_LOOUT) | cb(CB_GRA) | cb(CB_RIN);
        C_IN:                   w = cb(CB_INPORTOUT) | cb(CB_GRA) | cb(CB_RIN);
        C_OUT:                  w = cb(CB_GRA) | cb(CB_ROUT) | cb(CB_OUTPORTEN);
        default:                w = '0;
      endcase
      S_T4: case (c)
        C_ALU, C_MULDIV:        w = cb(CB_GRC) | cb(CB_ROUT) | cb(CB_ZEN);
        C_IMM, C_LD, C_LDI,
        C_ST:                   w = cb(CB_COUT) | cb(CB_ZEN);
        C_UNARY:                w = cb(CB_ZLOOUT) | cb(CB_GRA) | cb(CB_RIN);
        C_BR:                   w = cb(CB_PCOUT) | cb(CB_YEN);
        C_JAL:                  w = cb(CB_GRB) | cb(CB_ROUT) | cb(CB_PEN);
        default:                w = '0;
      endcase
      S_T5: case (c)
        C_ALU, C_IMM, C_LDI:    w = cb(CB_ZLOOUT) | cb(CB_GRA) | cb(CB_RIN);
        C_MULDIV:               w = cb(CB_ZLOOUT) | cb(CB_LOEN);
        C_LD, C_ST:             w = cb(CB_ZLOOUT) | cb(CB_MAREN);
        C_BR:                   w = cb(CB_COUT) | cb(CB_ZEN);
        default:                w = '0;
      endcase
      S_T6: case (c)
        C_MULDIV:               w = cb(CB_ZHIOUT) | cb(CB_HIEN);
        C_LD:                   w = cb(CB_READ) | cb(CB_MDREN);
        C_ST:                   w = cb(CB_GRA) | cb(CB_ROUT) | cb(CB_MDREN);
        C_BR:                   w = cb(CB_ZLOOUT) | (con ? cb(CB_PEN) : '0);
        default:                w = '0;
      endcase
      S_T7: case (c)
        C_LD:                   w = cb(CB_MDROUT) | cb(CB_GRA) | cb(CB_RIN);
        C_ST:                   w = cb(CB_WRITE);
        default:                w = '0;
      endcase
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/src_ctrl_seq_if.sv
// Datapath-facing signals of the control sequencer; master is the sequencer side.
interface src_ctrl_seq_if #(
  parameter int unsigned IR_W  = 32,
  parameter int unsigned OPC_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic [IR_W-1:0]  ir;
  logic             con_ff;
  logic             mem_ready;
  logic             stop;
  logic             go;
  logic [31:0]      ctrl;
  logic [OPC_W-1:0] alu_op;
  logic             run;
  logic             illegal;
  logic             mem_fault;
  logic [CNT_W-1:0] instr_count;
  logic [7:0]       state_dbg;

  modport master (
    input  ir, con_ff, mem_ready, stop, go,
    output ctrl, alu_op, run, illegal, mem_fault, instr_count, state_dbg
  );

  modport slave (
    output ir, con_ff, mem_ready, stop, go,
    input  ctrl, alu_op, run, illegal, mem_fault, instr_count, state_dbg
  );
endinterface

// File: rtl/src_mem_wait.sv
// Memory wait-state counter: counts cycles spent waiting for mem_ready and
// flags a timeout once MEM_TIMEOUT cycles have elapsed (0 disables it).
module src_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic done,
  output logic timeout
);
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic        TO_EN  = (MEM_TIMEOUT != 0);

  logic [WAIT_W-1:0] cnt;

  // Zero whenever idle, so every wait state starts from a cleared count
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (!active || mem_ready) cnt <= '0;
    else                         cnt <= cnt + WAIT_W'(1);
  end

  assign done    = active & mem_ready;
  assign timeout = active & ~mem_ready & TO_EN & (cnt == WAIT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/src_ctrl_seq.sv
// Mini SRC multi-cycle control sequencer: Moore FSM with memory wait-states,
// timeout/illegal faults, stop/go at instruction boundaries and retire count.
module src_ctrl_seq
  import src_ctrl_pkg::*;
#(
  parameter int unsigned IR_W        = 32,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  src_ctrl_seq_if.master bus
);
  state_t            state, nxt, boundary;
  op_class_t         cls_d, cls_q, cls_cur;
  logic [OPC_W-1:0]  opcode, alu_op_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  count_q;
  logic              run_q, illegal_q, mem_fault_q;
  logic              wait_st, mem_done, mem_timeout;
  logic              unused_ir;

  assign opcode    = bus.ir[IR_W-1 -: OPC_W];
  assign unused_ir = ^bus.ir;

  // Opcodes wider than the package's 5-bit values are illegal if any upper bit is set
  always_comb begin
    cls_d = C_ILL;
    if ((opcode >> 5) == '0) cls_d = classify(opcode[4:0]);
  end

  assign cls_cur  = (state == S_DEC) ? cls_d : cls_q;
  assign boundary = bus.stop ? S_HALT : S_F0;
  assign wait_st  = (state == S_F1) || (state == S_T6 && cls_q == C_LD) ||
                    (state == S_T7 && cls_q == C_ST);

  src_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clock     (clock),
    .reset     (reset),
    .active    (wait_st),
    .mem_ready (bus.mem_ready),
    .done      (mem_done),
    .timeout   (mem_timeout)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_RST: nxt = S_F0;
      S_F0:  nxt = S_F1;
      S_F1:  nxt = S_F2;
      S_F2:  nxt = S_DEC;
      S_DEC: case (cls_d)
        C_NOP:   nxt = boundary;
        C_HALT:  nxt = S_HALT;
        C_ILL:   nxt = S_FAULT;
        default: nxt = S_T3;
      endcase
      S_T3, S_T4, S_T5, S_T6, S_T7:
        nxt = (state == last_state(cls_q)) ? boundary : next_t(state);
      S_HALT: if (bus.go && !bus.stop) nxt = S_F0;
      default: nxt = S_FAULT;
    endcase
    // Completion beats timeout when both land on the same cycle
    if (wait_st && !mem_done) nxt = mem_timeout ? S_FAULT : state;
  end

  // Outputs are registered from the next state, so they track the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      cls_q       <= C_NOP;
      ctrl_q      <= '0;
      alu_op_q    <= '0;
      run_q       <= 1'b0;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_word(nxt, cls_cur, bus.con_ff);
      run_q  <= !(nxt == S_RST || nxt == S_HALT || nxt == S_FAULT);
      if (state == S_DEC) begin
        alu_op_q <= opcode;
        cls_q    <= cls_d;
        count_q  <= count_q + CNT_W'(1);
        if (cls_d == C_ILL) illegal_q <= 1'b1;
      end
      if (wait_st && !mem_done && mem_timeout) mem_fault_q <= 1'b1;
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.run         = run_q;
  assign bus.illegal     = illegal_q;
  assign bus.mem_fault   = mem_fault_q;
  assign bus.instr_count = count_q;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_src_ctrl_seq.sv
// Scoreboard bench for src_ctrl_seq: stimulus queues per-cycle expectations,
// a negedge monitor retires and compares them.
module tb_src_ctrl_seq;
  localparam logic [7:0] RST = 8'h00, F0 = 8'h01, F1 = 8'h02, F2 = 8'h03, DEC = 8'h04;
  localparam logic [7:0] T3 = 8'h05, T4 = 8'h06, T5 = 8'h07, T6 = 8'h08, T7 = 8'h09;
  localparam logic [7:0] HALT = 8'h0A, FAULT = 8'h0B;

  localparam int SEL_STATE = 0, SEL_CTRL = 1, SEL_ALUOP = 2, SEL_RUN = 3;
  localparam int SEL_ILL = 4, SEL_MF = 5, SEL_CNT = 6;

  localparam logic [31:0] C_F0     = 32'h0000_040D;
  localparam logic [31:0] C_F1     = 32'h0000_1052;
  localparam logic [31:0] C_ALU_T3 = 32'h0024_0200;
  localparam logic [31:0] C_ALU_T4 = 32'h0028_0400;
  localparam logic [31:0] C_ALU_T5 = 32'h0012_1000;
  localparam logic [31:0] C_LD_T3  = 32'h0044_0200;
  localparam logic [31:0] C_LD_T6  = 32'h0000_0050;
  localparam logic [31:0] C_LD_T7  = 32'h0012_0020;
  localparam logic [31:0] C_BR_T3  = 32'h0122_0000;
  localparam logic [31:0] C_MUL_T5 = 32'h0000_5000;
  localparam logic [31:0] C_MUL_T6 = 32'h0000_2800;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  src_ctrl_seq_if #(.IR_W(32), .OPC_W(5), .CNT_W(16)) bus ();

  src_ctrl_seq #(.IR_W(32), .OPC_W(5), .CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] act;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_STATE: return 32'(bus.state_dbg);
      SEL_CTRL:  return bus.ctrl;
      SEL_ALUOP: return 32'(bus.alu_op);
      SEL_RUN:   return 32'(bus.run);
      SEL_ILL:   return 32'(bus.illegal);
      SEL_MF:    return 32'(bus.mem_fault);
      SEL_CNT:   return 32'(bus.instr_count);
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; stale ones count as misses
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].sel);
        n_cmp++;
        if (act !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                   sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  function automatic void expc(input int d, input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = nm;
    e.sel  = sel;
    e.val  = v;
    sb.push_back(e);
  endfunction

  // Byte i of seq is the expected state i cycles after base
  function automatic void expst(input string nm, input int base, input logic [63:0] seq, input int n);
    for (int i = 0; i < n; i++) expc(base + i, nm, SEL_STATE, 32'(seq[8*i +: 8]));
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 27'd0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Leaves the DUT in F0 at offset 0
  task automatic reset_dut();
    reset = 1'b1;
    expc(0, "rst_state", SEL_STATE, 32'(RST));
    expc(0, "rst_ctrl", SEL_CTRL, 32'h0);
    expc(0, "rst_run", SEL_RUN, 32'h0);
    expc(0, "rst_aluop", SEL_ALUOP, 32'h0);
    expc(0, "rst_count", SEL_CNT, 32'h0);
    expc(0, "rst_illegal", SEL_ILL, 32'h0);
    expc(0, "rst_memfault", SEL_MF, 32'h0);
    tick(1);
    reset = 1'b0;
    expc(0, "rst_hold", SEL_STATE, 32'(RST));
    tick(1);
    expc(0, "rst_f0", SEL_STATE, 32'(F0));
    expc(0, "rst_f0_ctrl", SEL_CTRL, C_F0);
    expc(0, "rst_f0_run", SEL_RUN, 32'h1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.ir        = '0;
    bus.con_ff    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.stop      = 1'b0;
    bus.go        = 1'b0;
    @(posedge clock);
    #2;

    // add, zero-wait memory
    bus.ir = mk_ir(5'b00011);
    reset_dut();
    expst("add_seq", 0, 64'h0107060504030201, 8);
    expc(4, "add_aluop", SEL_ALUOP, 32'd3);
    expc(4, "add_count", SEL_CNT, 32'd1);
    expc(4, "add_t3_ctrl", SEL_CTRL, C_ALU_T3);
    expc(5, "add_t4_ctrl", SEL_CTRL, C_ALU_T4);
    expc(6, "add_t5_ctrl", SEL_CTRL, C_ALU_T5);
    expc(7, "add_f0_ctrl", SEL_CTRL, C_F0);
    tick(8);

    // reset while stalled in F1 of the second add
    bus.mem_ready = 1'b0;
    expc(0, "f1_stall_a", SEL_STATE, 32'(F1));
    expc(1, "f1_stall_b", SEL_STATE, 32'(F1));
    expc(1, "f1_stall_ctrl", SEL_CTRL, C_F1);
    tick(2);
    reset_dut();

    // F1 timeout with MEM_TIMEOUT=4
    expst("tmo_seq", 0, 64'h000B020202020201, 7);
    expc(5, "tmo_mf_pre", SEL_MF, 32'h0);
    expc(5, "tmo_ctrl_held", SEL_CTRL, C_F1);
    expc(6, "tmo_memfault", SEL_MF, 32'h1);
    expc(6, "tmo_run", SEL_RUN, 32'h0);
    expc(6, "tmo_ctrl", SEL_CTRL, 32'h0);
    tick(6);
    bus.go = 1'b1;
    expc(2, "fault_go_state", SEL_STATE, 32'(FAULT));
    expc(2, "fault_go_run", SEL_RUN, 32'h0);
    tick(3);
    bus.go = 1'b0;

    // mem_ready on the timeout cycle completes instead of faulting
    reset_dut();
    expst("tmo_edge_seq", 0, 64'h0403020202020201, 8);
    expc(6, "tmo_edge_mf", SEL_MF, 32'h0);
    tick(5);
    bus.mem_ready = 1'b1;
    tick(3);

    // ld with three wait cycles in T6
    bus.ir = mk_ir(5'b00000);
    reset_dut();
    expst("ld_seq_a", 0, 64'h0807060504030201, 8);
    expst("ld_seq_b", 8, 64'h0000000109080808, 5);
    expc(4, "ld_t3_ctrl", SEL_CTRL, C_LD_T3);
    for (int i = 7; i <= 10; i++) expc(i, "ld_t6_ctrl", SEL_CTRL, C_LD_T6);
    expc(11, "ld_t7_ctrl", SEL_CTRL, C_LD_T7);
    tick(7);
    bus.mem_ready = 1'b0;
    tick(3);
    bus.mem_ready = 1'b1;
    tick(3);

    // br, condition false then true
    for (int c = 0; c < 2; c++) begin
      bus.ir     = mk_ir(5'b10011);
      bus.con_ff = c[0];
      reset_dut();
      expst("br_seq", 0, 64'h0807060504030201, 8);
      expc(4, "br_t3_ctrl", SEL_CTRL, C_BR_T3);
      expc(7, "br_t6_ctrl", SEL_CTRL, (c == 1) ? 32'h0000_1002 : 32'h0000_1000);
      expc(8, "br_end", SEL_STATE, 32'(F0));
      tick(9);
    end
    bus.con_ff = 1'b0;

    // illegal opcode
    bus.ir = mk_ir(5'b11111);
    reset_dut();
    expc(3, "ill_dec", SEL_STATE, 32'(DEC));
    expc(3, "ill_flag_pre", SEL_ILL, 32'h0);
    expc(4, "ill_state", SEL_STATE, 32'(FAULT));
    expc(4, "ill_flag", SEL_ILL, 32'h1);
    expc(4, "ill_run", SEL_RUN, 32'h0);
    expc(4, "ill_count", SEL_CNT, 32'd1);
    expc(4, "ill_aluop", SEL_ALUOP, 32'h1F);
    tick(5);

    // nop goes straight back to fetch
    bus.ir = mk_ir(5'b11010);
    reset_dut();
    expc(3, "nop_dec_ctrl", SEL_CTRL, 32'h0);
    expc(4, "nop_f0", SEL_STATE, 32'(F0));
    expc(4, "nop_count", SEL_CNT, 32'd1);
    tick(5);

    // mul with stop raised mid-instruction, then stop+go, then go
    bus.ir = mk_ir(5'b01111);
    reset_dut();
    expst("mul_seq_a", 0, 64'h0807060504030201, 8);
    expst("mul_seq_b", 8, 64'h00000000010A0A0A, 4);
    expc(4, "mul_aluop", SEL_ALUOP, 32'h0F);
    expc(6, "mul_t5_ctrl", SEL_CTRL, C_MUL_T5);
    expc(7, "mul_t6_ctrl", SEL_CTRL, C_MUL_T6);
    expc(8, "halt_run", SEL_RUN, 32'h0);
    expc(8, "halt_ctrl", SEL_CTRL, 32'h0);
    expc(11, "resume_run", SEL_RUN, 32'h1);
    expc(11, "resume_ctrl", SEL_CTRL, C_F0);
    tick(5);
    bus.stop = 1'b1;
    tick(4);
    bus.go = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    tick(2);
    bus.go = 1'b0;

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
